// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the RV32 instruction fetch front end.
//   fetch_state_t  - fetch control states (hold after reset, running, halted on fault)
//   fetch_entry_t  - buffered instruction: PC plus instr_packet word
//   FETCH_PC_STEP  - byte distance between sequential fetches
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_HOLD,
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_fifo.sv
// instr_fetch_fifo: synchronous instruction buffer, DEPTH entries (power of 2, >= 2).
//   clock, reset  - clock and asynchronous active-high reset
//   push          - write push_data this cycle
//   push_data     - entry to write
//   pop           - remove head this cycle (ignored when empty)
//   flush         - discard all entries; overrides push and pop
//   head          - oldest entry (registered storage, visible the cycle after its write)
//   count         - number of stored entries
//   empty         - count == 0
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(do_pop);
        end
    end

    // The fetch credit rule keeps outstanding + stored <= DEPTH, so a push
    // can never meet a full buffer.
    no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push && !flush && count == FULL_COUNT));

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32 fetch front end. Owns the PC, issues word reads to instruction
// memory, buffers returned words and hands them to decode with valid/ready.
// Redirects from decode flush wrong-path work.
//   clock, reset                      - core clock, asynchronous active-high reset
//   imem_req_valid/ready/addr         - request channel to instruction memory
//   imem_resp_valid/data/err          - in-order response channel
//   instr, instr_pc, instr_valid/ready- instruction packet handshake to decode
//   redirect_valid, redirect_pc       - taken branch/jump target from decode
//   fetch_fault, fault_pc             - sticky fault flag and faulting PC
// Build option: FETCH_MISALIGN_TRAP_EN makes a misaligned redirect target raise a
// fault and halt; otherwise the target's low two bits are cleared.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t   state;
    fetch_state_t   state_next;
    logic [31:0]    pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  outstanding_next;
    logic [CW-1:0]  discard;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           accept;
    logic           resp_keep;
    logic           resp_fault;
    logic           push;
    logic           pop;
    logic           misalign;
    logic [31:0]    redirect_aligned;
    logic [31:0]    resp_pc;
    fetch_entry_t   push_data;
    fetch_entry_t   head;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign redirect_aligned = redirect_pc & ~32'h3;

    assign imem_req_addr    = pc;
    assign accept           = imem_req_valid && imem_req_ready;
    assign outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);

    // Responses return in order and pc has advanced once per accepted request,
    // so the oldest in-flight request sits `outstanding` steps behind pc. Only
    // meaningful when nothing is pending discard.
    assign resp_pc    = pc - 32'(outstanding) * FETCH_PC_STEP;
    assign resp_keep  = imem_resp_valid && (discard == '0) && !redirect_valid;
    assign resp_fault = resp_keep && imem_resp_err;
    assign push       = resp_keep && !imem_resp_err;
    assign push_data  = '{pc: resp_pc, word: imem_resp_data};
    assign pop        = instr_valid && instr_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        case (state)
            FETCH_HOLD: state_next = FETCH_RUN;
            FETCH_RUN: begin
                imem_req_valid = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS;
                if (resp_fault) begin
                    state_next = FETCH_HALT;
                end
            end
            FETCH_HALT: state_next = FETCH_HALT;
            default:    state_next = FETCH_HOLD;
        endcase
        if (redirect_valid) begin
            state_next = misalign ? FETCH_HALT : FETCH_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fetch_fault <= 1'b0;
            fault_pc    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this edge, including a request
                // accepted right now, belongs to the old path.
                pc          <= redirect_aligned;
                discard     <= outstanding_next;
                fetch_fault <= misalign;
                if (misalign) begin
                    fault_pc <= redirect_pc;
                end
            end else begin
                if (accept) begin
                    pc <= pc + FETCH_PC_STEP;
                end
                if (imem_resp_valid && discard != '0) begin
                    discard <= discard - CW'(1);
                end else if (resp_fault) begin
                    discard     <= outstanding_next;
                    fetch_fault <= 1'b1;
                    fault_pc    <= resp_pc;
                end
            end
        end
    end

    instr_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head.word;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized self-checking bench for instr_fetch. An instruction
// memory model answers requests in order with variable latency; a stream model
// predicts the PC/word sequence decode must see after each redirect.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NO_FAULT = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    always #5 clock = ~clock;

    int nchecks = 0;
    int nerrors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // stimulus knobs
    int          ready_pct, iready_pct, lat_min, lat_max, redir_pct;
    logic        force_redir;
    logic [31:0] force_pc;
    // memory / fault model
    logic        err_en;
    logic [31:0] err_addr;
    logic [31:0] exp_fault_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due;
    logic [31:0] acc_log[$];
    // stream model
    logic [31:0] exp_pc;
    int          cyc, first_acc, first_iv;
    logic        prev_ff;
    // per-cycle samples
    logic        s_rv, s_iv, s_ff;
    logic [31:0] s_ipc, s_idat, s_fpc;

    task automatic step();
        logic [31:0] ra, tgt, a;
        logic        rdy, irdy, rd;
        int          due;
        @(negedge clock);
        cyc++;
        s_rv  = imem_req_valid;
        ra    = imem_req_addr;
        s_iv  = instr_valid;
        s_ipc = instr_pc;
        s_idat = instr;
        s_ff  = fetch_fault;
        s_fpc = fault_pc;

        if (s_ff) check_eq("halt_no_req", 32'(s_rv), 32'd0);
        if (s_ff && !prev_ff) check_eq("fault_pc", s_fpc, exp_fault_pc);
        prev_ff = s_ff;
        check_eq("credit", 32'(pend_addr.size() <= DEPTH), 32'd1);

        rd = force_redir || ($urandom_range(99) < 32'(redir_pct));
        if (force_redir) tgt = force_pc;
        else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 32'd4;
        else tgt = $urandom & 32'h0000_0FFC;
        force_redir = 1'b0;
        rdy  = $urandom_range(99) < 32'(ready_pct);
        irdy = $urandom_range(99) < 32'(iready_pct);

        redirect_valid = rd;
        redirect_pc    = rd ? tgt : $urandom;
        imem_req_ready = rdy;
        instr_ready    = irdy;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            a = pend_addr.pop_front();
            void'(pend_due.pop_front());
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(a);
            imem_resp_err   = err_en && (a == err_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            imem_resp_err   = 1'b0;
        end

        if (s_rv && rdy) begin
            check_eq("req_align", {30'd0, ra[1:0]}, 32'd0);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due < last_due) due = last_due;
            last_due = due;
            pend_addr.push_back(ra);
            pend_due.push_back(due);
            acc_log.push_back(ra);
            if (first_acc < 0) first_acc = cyc;
        end
        if (s_iv && first_iv < 0) first_iv = cyc;
        if (rd) begin
            exp_pc = tgt & ~32'h3;
        end else if (s_iv && irdy) begin
            check_eq("pop_pc", s_ipc, exp_pc);
            check_eq("pop_data", s_idat, mem_word(s_ipc));
            if (err_en) check_eq("pop_past_fault", 32'(s_ipc == err_addr), 32'd0);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic redirect_to(input logic [31:0] t);
        force_redir = 1'b1;
        force_pc    = t;
        step();
    endtask

    task automatic wait_valid(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = s_iv;
        end
        check_eq(tag, 32'(got), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        imem_resp_err = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        force_redir = 1'b0; force_pc = '0; err_en = 1'b0; err_addr = '0;
        exp_fault_pc = NO_FAULT; exp_pc = RESET_PC; prev_ff = 1'b0;
        cyc = 0; first_acc = -1; first_iv = -1; last_due = 0;
        ready_pct = 100; iready_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;

        // asynchronous reset, checked before any clock edge
        #2 reset = 1'b1;
        #2;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_fault", 32'(fetch_fault), 32'd0);
        check_eq("rst_fault_pc", fault_pc, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // sequential fetch from reset, one-cycle memory
        repeat (12) step();
        check_eq("first_req_cycle", 32'(first_acc), 32'd1);
        check_eq("first_latency", 32'(first_iv - first_acc), 32'd2);
        check_eq("seq_cnt", 32'(acc_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check_eq("seq_addr", acc_log[i], 32'(i * 4));

        // decode stalled: buffer fills to depth, nothing more in flight
        iready_pct = 0;
        repeat (10) step();
        check_eq("stall_inflight", 32'(pend_addr.size()), 32'd0);
        check_eq("stall_valid", 32'(s_iv), 32'd1);
        iready_pct = 100;
        repeat (10) step();

        // redirect with two requests in flight
        lat_min = 4; lat_max = 4;
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                step();
                got = (pend_addr.size() == 2);
            end
            check_eq("two_inflight", 32'(got), 32'd1);
        end
        redirect_to(32'h0000_0100);
        iready_pct = 0;
        wait_valid("redir_wait");
        check_eq("redir_first_pc", s_ipc, 32'h0000_0100);
        check_eq("redir_first_data", s_idat, mem_word(32'h0000_0100));
        iready_pct = 100; lat_min = 1; lat_max = 1;

        // access fault on PC 0x8
        err_en = 1'b1; err_addr = 32'h8; exp_fault_pc = 32'h8;
        redirect_to(32'h0);
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                step();
                got = s_ff;
            end
            check_eq("fault_wait", 32'(got), 32'd1);
        end
        repeat (10) step();
        check_eq("fault_sticky", 32'(s_ff), 32'd1);
        check_eq("fault_pc_hold", s_fpc, 32'h8);
        check_eq("drain_stop", exp_pc, 32'h8);
        err_en = 1'b0; exp_fault_pc = NO_FAULT;
        iready_pct = 0;
        redirect_to(32'h0000_0040);
        wait_valid("recover_wait");
        check_eq("recover_pc", s_ipc, 32'h0000_0040);
        check_eq("fault_cleared", 32'(s_ff), 32'd0);
        iready_pct = 100;

        // PC wrap at the top of the address space
        redirect_to(32'hFFFF_FFF8);
        acc_log.delete();
        repeat (12) step();
        check_eq("wrap_cnt", 32'(acc_log.size() >= 3), 32'd1);
        check_eq("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
        check_eq("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
        check_eq("wrap_a2", acc_log[2], 32'h0000_0000);

        // misaligned redirect target
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_fault_pc = 32'h0000_0102;
        redirect_to(32'h0000_0102);
        repeat (5) step();
        check_eq("trap_fault", 32'(s_ff), 32'd1);
        check_eq("trap_fault_pc", s_fpc, 32'h0000_0102);
        exp_fault_pc = NO_FAULT;
        redirect_to(32'h0000_0200);
`else
        iready_pct = 0;
        redirect_to(32'h0000_0102);
        wait_valid("misalign_wait");
        check_eq("misalign_pc", s_ipc, 32'h0000_0100);
        check_eq("misalign_no_fault", 32'(s_ff), 32'd0);
        iready_pct = 100;
`endif

        // randomized traffic
        for (int blk = 0; blk < 20; blk++) begin
            ready_pct  = int'($urandom_range(100, 30));
            iready_pct = int'($urandom_range(100, 20));
            lat_min    = 1;
            lat_max    = int'($urandom_range(5, 1));
            redir_pct  = int'($urandom_range(5, 0));
            repeat (100) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
